// File: rtl/valu_pkg.sv
// -----------------------------------------------------------------------------
// valu_pkg
// Shared definitions for the multi-beat vector ALU (vector_alu_seq):
//   - opcode encodings OP_VADD .. OP_VMACCVARP
//   - FSM state enum {IDLE, RUN, DONE}
//   - legal SEW constants and the sew_legal() helper
//   - opcode helpers: legality, varp flag, and base arithmetic kind
// -----------------------------------------------------------------------------
package valu_pkg;

    localparam logic [7:0] OP_VADD      = 8'h00;
    localparam logic [7:0] OP_VSUB      = 8'h01;
    localparam logic [7:0] OP_VMUL      = 8'h02;
    localparam logic [7:0] OP_VMACC     = 8'h03;
    localparam logic [7:0] OP_VMULVARP  = 8'h04;
    localparam logic [7:0] OP_VADDVARP  = 8'h05;
    localparam logic [7:0] OP_VSUBVARP  = 8'h06;
    localparam logic [7:0] OP_VMACCVARP = 8'h07;

    localparam logic [6:0] SEW_8  = 7'd8;
    localparam logic [6:0] SEW_16 = 7'd16;
    localparam logic [6:0] SEW_32 = 7'd32;
    localparam logic [6:0] SEW_64 = 7'd64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } valu_state_e;

    // Arithmetic performed per element once varp masking has been applied.
    typedef enum logic [1:0] {
        K_ADD  = 2'd0,
        K_SUB  = 2'd1,
        K_MUL  = 2'd2,
        K_MACC = 2'd3
    } valu_kind_e;

    function automatic logic sew_legal(input logic [6:0] sew);
        return (sew == SEW_8) || (sew == SEW_16) || (sew == SEW_32) || (sew == SEW_64);
    endfunction

    function automatic logic op_legal(input logic [7:0] op);
        return op <= OP_VMACCVARP;
    endfunction

    function automatic logic op_is_varp(input logic [7:0] op);
        return (op >= OP_VMULVARP) && (op <= OP_VMACCVARP);
    endfunction

    // The varp opcodes are not in the same order as the plain ones
    // (04 is mul, 05 add, 06 sub, 07 macc), so map explicitly.
    function automatic valu_kind_e op_kind(input logic [7:0] op);
        valu_kind_e k;
        case (op)
            OP_VADD, OP_VADDVARP:   k = K_ADD;
            OP_VSUB, OP_VSUBVARP:   k = K_SUB;
            OP_VMUL, OP_VMULVARP:   k = K_MUL;
            OP_VMACC, OP_VMACCVARP: k = K_MACC;
            default:                k = K_ADD;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/vector_alu_seq_if.sv
// -----------------------------------------------------------------------------
// vector_alu_seq_if
// Request/response bundle of the vector ALU.
//   Request : in_valid, in_ready, instruction[7:0], sew[6:0], vap[3:0],
//             vl[VLW-1:0], opA/opB/opC[VLEN-1:0]
//   Response: out_valid, out_ready, alu_out[VLEN-1:0], err
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. The source holds valid and its payload stable until that edge;
// ready may be asserted regardless of valid.
// Modports: master = requester/consumer side, slave = the ALU.
// -----------------------------------------------------------------------------
interface vector_alu_seq_if #(
    parameter int VLEN = 512
);
    localparam int VLW = $clog2(VLEN / 8) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [7:0]      instruction;
    logic [6:0]      sew;
    logic [3:0]      vap;
    logic [VLW-1:0]  vl;
    logic [VLEN-1:0] opA;
    logic [VLEN-1:0] opB;
    logic [VLEN-1:0] opC;
    logic            out_valid;
    logic            out_ready;
    logic [VLEN-1:0] alu_out;
    logic            err;

    modport master (
        output in_valid, instruction, sew, vap, vl, opA, opB, opC, out_ready,
        input  in_ready, out_valid, alu_out, err
    );

    modport slave (
        input  in_valid, instruction, sew, vap, vl, opA, opB, opC, out_ready,
        output in_ready, out_valid, alu_out, err
    );
endinterface

// File: rtl/valu_beat.sv
// -----------------------------------------------------------------------------
// valu_beat
// Combinational BEAT_W-bit slice of the vector ALU.
// Ports:
//   a, b, c    in  BEAT_W  operand slices
//   sew        in  7       element width (8/16/32/64 legal)
//   vap        in  4       varp precision (low bits of a/b forced to zero)
//   opcode     in  8       instruction opcode
//   first_idx  in  VLW     vector index of the slice's first element
//   vl         in  VLW     active element count
//   res        out BEAT_W  result slice
// Elements with index >= vl, and the whole slice for an illegal sew/opcode,
// pass c through unchanged.
// Build option: VALU_SAT_EN makes add/sub (plain and varp) saturate as signed
// SEW values; multiply and multiply-accumulate always wrap.
// -----------------------------------------------------------------------------
module valu_beat
    import valu_pkg::*;
#(
    parameter int BEAT_W = 128,
    parameter int VLW    = 7
) (
    input  logic [BEAT_W-1:0] a,
    input  logic [BEAT_W-1:0] b,
    input  logic [BEAT_W-1:0] c,
    input  logic [6:0]        sew,
    input  logic [3:0]        vap,
    input  logic [7:0]        opcode,
    input  logic [VLW-1:0]    first_idx,
    input  logic [VLW-1:0]    vl,
    output logic [BEAT_W-1:0] res
);

`ifdef VALU_SAT_EN
    // Signed saturating add/sub of two w-bit patterns held in 64-bit words.
    // Both inputs are sign-extended from bit w-1 into a 66-bit workspace so
    // the unclamped result can never overflow, even for w = 64.
    function automatic logic [63:0] sat_addsub(input logic [63:0] ra, input logic [63:0] rb,
                                               input logic sub, input int w);
        logic [65:0] sign_bit, xa, xb, s, max_v, min_v;
        sign_bit = 66'd1 << (w - 1);
        xa       = ({2'b00, ra} ^ sign_bit) - sign_bit;
        xb       = ({2'b00, rb} ^ sign_bit) - sign_bit;
        s        = sub ? (xa - xb) : (xa + xb);
        max_v    = sign_bit - 66'd1;
        min_v    = -sign_bit;
        if ($signed(s) > $signed(max_v)) begin
            s = max_v;
        end else if ($signed(s) < $signed(min_v)) begin
            s = min_v;
        end
        return s[63:0];
    endfunction
`endif

    // One element of width w; w is a constant at every call site.
    function automatic logic [63:0] elem_op(input logic [63:0] ea, input logic [63:0] eb,
                                            input logic [63:0] ec, input valu_kind_e kind,
                                            input logic varp, input logic [3:0] vap_i,
                                            input int w);
        logic [63:0] mask, vmask, ra, rb, r;
        int          nm;
        mask  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        ra    = ea & mask;
        rb    = eb & mask;
        // At most SEW-1 bits are masked so the element keeps its top bit.
        nm    = (int'(vap_i) < (w - 1)) ? int'(vap_i) : (w - 1);
        vmask = ~((64'd1 << nm) - 64'd1);
        if (varp) begin
            ra = ra & vmask;
            rb = rb & vmask;
        end
        case (kind)
            K_ADD:   r = ra + rb;
            K_SUB:   r = ra - rb;
            K_MUL:   r = ra * rb;
            default: r = ra * rb + (ec & mask);
        endcase
`ifdef VALU_SAT_EN
        if ((kind == K_ADD) || (kind == K_SUB)) begin
            r = sat_addsub(ra, rb, kind == K_SUB, w);
        end
`endif
        return r & mask;
    endfunction

    valu_kind_e  kind;
    logic        varp;
    logic [63:0] e;

    assign kind = op_kind(opcode);
    assign varp = op_is_varp(opcode);

    always_comb begin
        res = c;
        e   = '0;
        if (sew_legal(sew) && op_legal(opcode)) begin
            case (sew)
                SEW_8: begin
                    for (int i = 0; i < BEAT_W / 8; i++) begin
                        e = elem_op(64'(a[i*8 +: 8]), 64'(b[i*8 +: 8]), 64'(c[i*8 +: 8]),
                                    kind, varp, vap, 8);
                        if (int'(first_idx) + i < int'(vl)) res[i*8 +: 8] = e[7:0];
                    end
                end
                SEW_16: begin
                    for (int i = 0; i < BEAT_W / 16; i++) begin
                        e = elem_op(64'(a[i*16 +: 16]), 64'(b[i*16 +: 16]), 64'(c[i*16 +: 16]),
                                    kind, varp, vap, 16);
                        if (int'(first_idx) + i < int'(vl)) res[i*16 +: 16] = e[15:0];
                    end
                end
                SEW_32: begin
                    for (int i = 0; i < BEAT_W / 32; i++) begin
                        e = elem_op(64'(a[i*32 +: 32]), 64'(b[i*32 +: 32]), 64'(c[i*32 +: 32]),
                                    kind, varp, vap, 32);
                        if (int'(first_idx) + i < int'(vl)) res[i*32 +: 32] = e[31:0];
                    end
                end
                default: begin
                    for (int i = 0; i < BEAT_W / 64; i++) begin
                        e = elem_op(a[i*64 +: 64], b[i*64 +: 64], c[i*64 +: 64],
                                    kind, varp, vap, 64);
                        if (int'(first_idx) + i < int'(vl)) res[i*64 +: 64] = e;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/vector_alu_seq.sv
// -----------------------------------------------------------------------------
// vector_alu_seq
// Multi-beat vector ALU: accepts one op per request handshake, processes VLEN
// bits in BEAT_W slices (one per cycle) and holds the result until accepted.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   bus        slave modport of vector_alu_seq_if (request + response)
//   dbg_state  out  current FSM state
// Parameters: VLEN (multiple of BEAT_W), BEAT_W (multiple of 64).
// Build option: VALU_SAT_EN selects saturating add/sub inside valu_beat.
// Timing: acceptance edge -> out_valid rises NBEATS edges later; in_ready is
// high only in IDLE and returns the cycle after the result is accepted.
// -----------------------------------------------------------------------------
module vector_alu_seq
    import valu_pkg::*;
#(
    parameter int VLEN   = 512,
    parameter int BEAT_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    vector_alu_seq_if.slave   bus,
    output valu_state_e       dbg_state
);

    localparam int NBEATS = VLEN / BEAT_W;
    localparam int VLW    = $clog2(VLEN / 8) + 1;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    valu_state_e      state;
    logic [CNT_W-1:0] beat_cnt;
    logic [VLEN-1:0]  opa_q, opb_q, opc_q, res_q;
    logic [7:0]       op_q;
    logic [6:0]       sew_q;
    logic [3:0]       vap_q;
    logic [VLW-1:0]   vl_q;
    logic             in_ready_q, out_valid_q, err_q;

    logic [BEAT_W-1:0] a_sl, b_sl, c_sl, beat_res;
    logic [VLW-1:0]    first_idx;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_out   = res_q;
    assign bus.err       = err_q;
    assign dbg_state     = state;

    // No vl clamp is needed: element indices never exceed VLEN/SEW-1, so any
    // vl >= VLEN/SEW already makes every element active.
    always_comb begin
        a_sl      = opa_q[int'(beat_cnt)*BEAT_W +: BEAT_W];
        b_sl      = opb_q[int'(beat_cnt)*BEAT_W +: BEAT_W];
        c_sl      = opc_q[int'(beat_cnt)*BEAT_W +: BEAT_W];
        first_idx = '0;
        case (sew_q)
            SEW_8:   first_idx = VLW'(int'(beat_cnt) * (BEAT_W / 8));
            SEW_16:  first_idx = VLW'(int'(beat_cnt) * (BEAT_W / 16));
            SEW_32:  first_idx = VLW'(int'(beat_cnt) * (BEAT_W / 32));
            SEW_64:  first_idx = VLW'(int'(beat_cnt) * (BEAT_W / 64));
            default: first_idx = '0;
        endcase
    end

    valu_beat #(
        .BEAT_W (BEAT_W),
        .VLW    (VLW)
    ) u_beat (
        .a         (a_sl),
        .b         (b_sl),
        .c         (c_sl),
        .sew       (sew_q),
        .vap       (vap_q),
        .opcode    (op_q),
        .first_idx (first_idx),
        .vl        (vl_q),
        .res       (beat_res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            opc_q       <= '0;
            res_q       <= '0;
            op_q        <= '0;
            sew_q       <= '0;
            vap_q       <= '0;
            vl_q        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        opa_q      <= bus.opA;
                        opb_q      <= bus.opB;
                        opc_q      <= bus.opC;
                        op_q       <= bus.instruction;
                        sew_q      <= bus.sew;
                        vap_q      <= bus.vap;
                        vl_q       <= bus.vl;
                        beat_cnt   <= '0;
                        err_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    res_q[int'(beat_cnt)*BEAT_W +: BEAT_W] <= beat_res;
                    if (beat_cnt == CNT_W'(NBEATS - 1)) begin
                        beat_cnt    <= '0;
                        out_valid_q <= 1'b1;
                        err_q       <= !(sew_legal(sew_q) && op_legal(op_q));
                        state       <= DONE;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_vector_alu_seq
// Self-checking bench for vector_alu_seq: directed cases plus randomized ops,
// compared against an element-level arithmetic model kept in this file.
// -----------------------------------------------------------------------------
module tb_vector_alu_seq;
    import valu_pkg::*;

    localparam int VLEN   = 512;
    localparam int BEAT_W = 128;
    localparam int NBEATS = VLEN / BEAT_W;
    localparam int VLW    = $clog2(VLEN / 8) + 1;
    localparam int W      = VLEN + 1;   // {err, alu_out}

    // ---------------- clock / reset ----------------
    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    valu_state_e dbg_state;

    always #5 clk = ~clk;

    vector_alu_seq_if #(.VLEN(VLEN)) bus ();

    vector_alu_seq #(
        .VLEN   (VLEN),
        .BEAT_W (BEAT_W)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int             n_checks = 0;
    int             n_fail   = 0;
    logic [W-1:0]   exp_q[$];

    task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Works element by element with wide unsigned arithmetic and explicit
    // modulo; returns {err, result}.
    function automatic logic [W-1:0] model(input logic [7:0] op, input logic [6:0] sew,
                                           input logic [3:0] vap, input logic [VLW-1:0] vl,
                                           input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                                           input logic [VLEN-1:0] c);
        logic [VLEN-1:0]    r, emask;
        logic [129:0]       md, ea, eb, ec, q, v;
        logic signed [131:0] sa, sb, sr, hi, lo;
        int                 n, m, s;
        if (!(sew inside {7'd8, 7'd16, 7'd32, 7'd64}) || op > 8'd7) return {1'b1, c};
        s  = int'(sew);
        md = 130'd1 << s;
        n  = VLEN / s;
        r  = c;
        for (int i = 0; i < n; i++) begin
            if (i >= int'(vl)) continue;
            ea = 130'((a >> (i * s)) % VLEN'(md));
            eb = 130'((b >> (i * s)) % VLEN'(md));
            ec = 130'((c >> (i * s)) % VLEN'(md));
            if (op >= 8'd4) begin
                m  = (int'(vap) < s - 1) ? int'(vap) : s - 1;
                q  = 130'd1 << m;
                ea = ea - (ea % q);
                eb = eb - (eb % q);
            end
            case (op)
                8'd0, 8'd5: v = (ea + eb) % md;
                8'd1, 8'd6: v = (ea + md - eb) % md;
                8'd2, 8'd4: v = (ea * eb) % md;
                default:    v = (ea * eb + ec) % md;
            endcase
`ifdef VALU_SAT_EN
            if (op inside {8'd0, 8'd1, 8'd5, 8'd6}) begin
                hi = (md >> 1) - 1;
                lo = -(md >> 1);
                sa = ea;
                sb = eb;
                if (ea >= (md >> 1)) sa = sa - md;
                if (eb >= (md >> 1)) sb = sb - md;
                sr = (op == 8'd1 || op == 8'd6) ? (sa - sb) : (sa + sb);
                if (sr > hi) sr = hi;
                else if (sr < lo) sr = lo;
                if (sr < 0) sr = sr + md;
                v = sr[129:0];
            end
`endif
            emask = VLEN'(md - 1) << (i * s);
            r = (r & ~emask) | (VLEN'(v) << (i * s));
        end
        return {1'b0, r};
    endfunction

    function automatic logic [VLEN-1:0] fill(input int sew, input logic [63:0] val);
        logic [VLEN-1:0] v = '0;
        for (int i = 0; i < VLEN / sew; i++) v = v | (VLEN'(val) << (i * sew));
        return v;
    endfunction

    function automatic logic [VLEN-1:0] rand_vec();
        logic [VLEN-1:0] v;
        for (int i = 0; i < VLEN / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [7:0] op, input logic [6:0] sew, input logic [3:0] vap,
                         input logic [VLW-1:0] vl, input logic [VLEN-1:0] a,
                         input logic [VLEN-1:0] b, input logic [VLEN-1:0] c);
        int waited = 0;
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.instruction = op;
        bus.sew         = sew;
        bus.vap         = vap;
        bus.vl          = vl;
        bus.opA         = a;
        bus.opB         = b;
        bus.opC         = c;
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("accept_wait", VLEN'(waited < 20), VLEN'(1));
        exp_q.push_back(model(op, sew, vap, vl, a, b, c));
        @(posedge clk);
        #1;
        check("in_ready_after_accept", VLEN'(bus.in_ready), '0);
        @(negedge clk);
        // Scramble the request so only the captured copy can produce the result.
        bus.in_valid    = 1'b0;
        bus.instruction = 8'($urandom);
        bus.sew         = 7'($urandom);
        bus.vap         = 4'($urandom);
        bus.vl          = VLW'($urandom);
        bus.opA         = rand_vec();
        bus.opB         = rand_vec();
        bus.opC         = rand_vec();
    endtask

    // Waits for out_valid (counting edges from acceptance) and checks the result.
    task automatic wait_done(input string tag, output logic [W-1:0] exp);
        int lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, VLEN'(lat), VLEN'(NBEATS));
        exp = '0;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        check({tag, "_alu_out"}, bus.alu_out, exp[VLEN-1:0]);
        check({tag, "_err"}, VLEN'(bus.err), VLEN'(exp[VLEN]));
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_out_valid_drop"}, VLEN'(bus.out_valid), '0);
        check({tag, "_in_ready_back"}, VLEN'(bus.in_ready), VLEN'(1));
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [7:0] op, input logic [6:0] sew,
                          input logic [3:0] vap, input logic [VLW-1:0] vl,
                          input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                          input logic [VLEN-1:0] c, output logic [W-1:0] exp);
        issue(op, sew, vap, vl, a, b, c);
        wait_done(tag, exp);
        release_out(tag);
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0]    e;
    logic [VLEN-1:0] va, vb, vc;
    logic [6:0]      sew_tab[5] = '{7'd8, 7'd16, 7'd32, 7'd64, 7'd12};

    initial begin
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.instruction = '0;
        bus.sew         = '0;
        bus.vap         = '0;
        bus.vl          = '0;
        bus.opA         = '0;
        bus.opB         = '0;
        bus.opC         = '0;

        // Reset values
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", VLEN'(bus.in_ready), '0);
        check("rst_out_valid", VLEN'(bus.out_valid), '0);
        check("rst_alu_out", bus.alu_out, '0);
        check("rst_err", VLEN'(bus.err), '0);
        check("rst_state", VLEN'(dbg_state), VLEN'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", VLEN'(bus.in_ready), VLEN'(1));

        // 1. vadd sew16, all elements 1 + 2
        run_op("vadd16", 8'h00, 7'd16, 4'd0, VLW'(32), fill(16, 64'h1), fill(16, 64'h2),
               rand_vec(), e);
        check("vadd16_const", e[VLEN-1:0], fill(16, 64'h3));

        // 2. vmacc sew16 element 0, and vmul sew32
        va = '0; vb = '0; vc = '0;
        va[15:0] = 16'h1111; vb[15:0] = 16'h0003; vc[15:0] = 16'h0001;
        run_op("vmacc16", 8'h03, 7'd16, 4'd0, VLW'(32), va, vb, vc, e);
        check("vmacc16_e0", VLEN'(e[15:0]), VLEN'(16'h3334));
        run_op("vmul32", 8'h02, 7'd32, 4'd0, VLW'(16), fill(32, 64'h00010001),
               fill(32, 64'h00010001), '0, e);
        check("vmul32_const", e[VLEN-1:0], fill(32, 64'h00020001));

        // 3. varp masking
        run_op("vaddvarp_v3", 8'h05, 7'd8, 4'd3, VLW'(64), fill(8, 64'h0F), fill(8, 64'h0F),
               '0, e);
        check("vaddvarp_v3_const", e[VLEN-1:0], fill(8, 64'h10));
        run_op("vaddvarp_v15", 8'h05, 7'd8, 4'd15, VLW'(64), fill(8, 64'hFF), fill(8, 64'hFF),
               '0, e);
`ifdef VALU_SAT_EN
        check("vaddvarp_v15_const", e[VLEN-1:0], fill(8, 64'h80));
`else
        check("vaddvarp_v15_const", e[VLEN-1:0], fill(8, 64'h00));
`endif

        // 4. vsub with tail
        vc = fill(32, 64'hDEADBEEF);
        run_op("vsub_tail", 8'h01, 7'd32, 4'd0, VLW'(5), fill(32, 64'h1), fill(32, 64'h2),
               vc, e);
        va = vc;
        for (int i = 0; i < 5; i++) va[i*32 +: 32] = 32'hFFFFFFFF;
        check("vsub_tail_const", e[VLEN-1:0], va);

        // 5. hold DONE for 10 cycles with a competing request, then reset mid-RUN
        issue(8'h00, 7'd64, 4'd0, VLW'(8), rand_vec(), rand_vec(), rand_vec());
        wait_done("hold", e);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.in_valid    = 1'b1;
            bus.instruction = 8'h02;
            bus.opA         = rand_vec();
            @(posedge clk);
            #1;
            check("hold_alu_out", bus.alu_out, e[VLEN-1:0]);
            check("hold_out_valid", VLEN'(bus.out_valid), VLEN'(1));
            check("hold_in_ready", VLEN'(bus.in_ready), '0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        release_out("hold");

        issue(8'h00, 7'd8, 4'd0, VLW'(64), fill(8, 64'h11), fill(8, 64'h22), '0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_out_valid", VLEN'(bus.out_valid), '0);
        check("midrun_alu_out", bus.alu_out, '0);
        check("midrun_in_ready", VLEN'(bus.in_ready), '0);
        check("midrun_state", VLEN'(dbg_state), VLEN'(IDLE));
        void'(exp_q.pop_front());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_recover_in_ready", VLEN'(bus.in_ready), VLEN'(1));

        // 6. illegal sew / opcode, and signed-overflow add
        vc = rand_vec();
        run_op("sew12", 8'h00, 7'd12, 4'd0, VLW'(40), rand_vec(), rand_vec(), vc, e);
        check("sew12_opc", e[VLEN-1:0], vc);
        vc = rand_vec();
        run_op("op09", 8'h09, 7'd16, 4'd0, VLW'(32), rand_vec(), rand_vec(), vc, e);
        run_op("vadd8_ovf", 8'h00, 7'd8, 4'd0, VLW'(64), fill(8, 64'h7F), fill(8, 64'h01), '0, e);
`ifdef VALU_SAT_EN
        check("vadd8_ovf_const", e[VLEN-1:0], fill(8, 64'h7F));
`else
        check("vadd8_ovf_const", e[VLEN-1:0], fill(8, 64'h80));
`endif

        // Randomized ops
        for (int t = 0; t < 30; t++) begin
            run_op("rand", 8'($urandom_range(0, 9)), sew_tab[$urandom_range(0, 4)],
                   4'($urandom_range(0, 15)), VLW'($urandom_range(0, 80)),
                   rand_vec(), rand_vec(), rand_vec(), e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
